// File: rtl/pe_os_row_drain_16.sv
// rtl/pe_os_row_drain_16.sv - row controller/collector for one row of output-stationary PEs
//
// Purpose:
//   On START it clears the PE row, waits out the operand stream, pipeline fill
//   and row skew, snapshots every PE's MAC_OUT into shadow registers and streams
//   the snapshot out one result per beat over a valid/ready link.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   START      in   1-cycle tile start pulse (only honoured in IDLE)
//   K_LEN      in   operand pairs per PE for the tile, sampled with START
//   MAC_IN     in   flattened PE accumulators, PE j at [j*ACC_W +: ACC_W]
//   PE_RST_N   out  active-low clear to the PE row
//   BUSY       out  high whenever not IDLE
//   OUT_VALID  out  result beat valid
//   OUT_READY  in   downstream accepts the beat
//   OUT_DATA   out  result of PE OUT_IDX
//   OUT_IDX    out  PE index of the current beat
//   DONE       out  1-cycle pulse on acceptance of the last beat
//
// Configuration macro:
//   DRAIN_SAT_EN  when defined, each beat is saturated to the signed WIDTH range
//                 and sign-extended to ACC_W; otherwise the raw accumulator is sent.

module pe_os_row_drain_16 #(
   parameter int WIDTH    = 16,
   parameter int ACC_W    = 32,
   parameter int NUM_PE   = 8,
   parameter int FILL_LAT = 3,
   parameter int IDX_W    = 3
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic [15:0]               K_LEN,
   input  logic [NUM_PE*ACC_W-1:0]   MAC_IN,
   output logic                      PE_RST_N,
   output logic                      BUSY,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [ACC_W-1:0]          OUT_DATA,
   output logic [IDX_W-1:0]          OUT_IDX,
   output logic                      DONE
);

   localparam int CNT_W = 17;
   localparam logic [CNT_W-1:0] WAIT_EXTRA = CNT_W'(FILL_LAT + NUM_PE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_ACC   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [15:0]       kreg;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ACC_W-1:0]  shadow [NUM_PE];

   logic              pe_rst_n_d;
   logic              busy_d;
   logic              valid_d;
   logic              done_d;
   logic [IDX_W-1:0]  idx_d;
   logic [ACC_W-1:0]  data_d;

   logic              accept;
   logic              last_beat;
   logic              capture;
   logic [IDX_W-1:0]  idx_next;

   assign accept    = OUT_VALID & OUT_READY;
   assign last_beat = (OUT_IDX == LAST_IDX);
   assign capture   = (state_q == S_ACC) && (wait_cnt == '0);
   assign idx_next  = OUT_IDX + IDX_W'(1);

   // Per-beat output shaping, applied on the way into the OUT_DATA register.
   function automatic logic [ACC_W-1:0] shape(input logic [ACC_W-1:0] v);
`ifdef DRAIN_SAT_EN
      logic fits;
      // The value fits the WIDTH range iff all bits from the WIDTH sign bit up agree.
      fits = (v[ACC_W-1:WIDTH-1] == '0) || (v[ACC_W-1:WIDTH-1] == '1);
      if (fits)
         shape = v;
      else if (v[ACC_W-1])
         shape = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      else
         shape = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
`else
      shape = v;
`endif
   endfunction

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_CLR;
         S_CLR:   state_d = S_ACC;
         S_ACC:   if (wait_cnt == '0) state_d = S_DRAIN;
         S_DRAIN: if (accept && last_beat) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      pe_rst_n_d = (state_d != S_CLR);
      busy_d     = (state_d != S_IDLE);
      valid_d    = (state_d == S_DRAIN);
      done_d     = (state_q == S_DRAIN) && accept && last_beat;
      idx_d      = OUT_IDX;
      data_d     = OUT_DATA;
      if (capture) begin
         // shadow[0] is being loaded this same edge, so read the PE directly.
         idx_d  = '0;
         data_d = shape(MAC_IN[0 +: ACC_W]);
      end else if ((state_q == S_DRAIN) && accept && !last_beat) begin
         idx_d  = idx_next;
         data_d = shape(shadow[idx_next]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PE_RST_N  <= 1'b0;
         BUSY      <= 1'b0;
         OUT_VALID <= 1'b0;
         DONE      <= 1'b0;
         OUT_IDX   <= '0;
         OUT_DATA  <= '0;
      end else begin
         PE_RST_N  <= pe_rst_n_d;
         BUSY      <= busy_d;
         OUT_VALID <= valid_d;
         DONE      <= done_d;
         OUT_IDX   <= idx_d;
         OUT_DATA  <= data_d;
      end
   end

   // Tile length, wait counter and snapshot
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         kreg     <= '0;
         wait_cnt <= '0;
         for (int j = 0; j < NUM_PE; j++)
            shadow[j] <= '0;
      end else begin
         if ((state_q == S_IDLE) && START)
            kreg <= K_LEN;
         if (state_q == S_CLR)
            wait_cnt <= {1'b0, kreg} + WAIT_EXTRA;
         else if ((state_q == S_ACC) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - CNT_W'(1);
         if (capture) begin
            for (int j = 0; j < NUM_PE; j++)
               shadow[j] <= MAC_IN[j*ACC_W +: ACC_W];
         end
      end
   end

endmodule

// File: tb/tb_pe_os_row_drain_16.sv
// tb/tb_pe_os_row_drain_16.sv - table-driven self-checking bench for pe_os_row_drain_16
module tb_pe_os_row_drain_16;

   localparam int NPE  = 8;
   localparam int FILL = 3;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          START = 1'b0;
   logic [15:0]   K_LEN = '0;
   logic [255:0]  MAC_IN;
   logic          PE_RST_N;
   logic          BUSY;
   logic          OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic [31:0]   OUT_DATA;
   logic [2:0]    OUT_IDX;
   logic          DONE;

   int checks = 0;
   int errors = 0;

   pe_os_row_drain_16 dut (
      .CLK(CLK), .RST(RST), .START(START), .K_LEN(K_LEN), .MAC_IN(MAC_IN),
      .PE_RST_N(PE_RST_N), .BUSY(BUSY), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // Row model: operand pair i reaches PE j in ACC cycle i+j; its product is
   // visible in MAC_OUT from cycle i+j+FILL+1 on. c counts cycles since clear.
   int tile_k = 0;
   int tile_y = 0;
   int px [NPE];
   int c = 0;

   always @(negedge CLK) begin
      if (!PE_RST_N) c = 0;
      else if (c < 100000) c = c + 1;
   end

   always_comb begin
      MAC_IN = '0;
      for (int j = 0; j < NPE; j++) begin
         int n;
         n = c - 1 - j - FILL;
         if (n < 0) n = 0;
         if (n > tile_k) n = tile_k;
         MAC_IN[j*32 +: 32] = 32'(n * px[j] * tile_y);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      int k;
      int xs;
      int xc;
      int y;
      int stall_idx;
      int stall_len;
      int lat;
      int e0;
      int estep;
      bit repulse;
   } vec_t;

   vec_t vecs [7];

   task automatic run_tile(input vec_t v);
      int  n;
      int  b;
      int  dc;
      int  stalled;
      int  dones;
      for (int j = 0; j < NPE; j++) px[j] = v.xs * (j + 1) + v.xc;
      tile_k = v.k;
      tile_y = v.y;
      @(posedge CLK); #1;
      K_LEN = 16'(v.k);
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("busy_after_start", 32'(BUSY), 32'd1);
      n = 0;
      dones = 0;
      while (!OUT_VALID && n < 200) begin
         if (v.repulse && n == 3) START = 1'b1;
         else START = 1'b0;
         @(posedge CLK); #1;
         n++;
         if (DONE) dones++;
      end
      START = 1'b0;
      chk("first_valid_latency", 32'(n), 32'(v.lat));
      b = 0; dc = 0; stalled = 0;
      while (b < NPE && dc < 100) begin
         chk("drain_valid", 32'(OUT_VALID), 32'd1);
         chk("drain_idx", 32'(OUT_IDX), 32'(b));
         chk("drain_data", OUT_DATA, 32'(v.e0 + b * v.estep));
         chk("drain_no_done", 32'(DONE), 32'd0);
         if (b == v.stall_idx && stalled < v.stall_len) begin
            OUT_READY = 1'b0;
            stalled++;
         end else begin
            OUT_READY = 1'b1;
         end
         START = (v.repulse && dc == 1);
         @(posedge CLK); #1;
         if (OUT_READY) b++;
         dc++;
      end
      START = 1'b0;
      OUT_READY = 1'b0;
      chk("drain_cycles", 32'(dc), 32'(NPE + (v.stall_idx >= 0 ? v.stall_len : 0)));
      chk("done_pulse", 32'(DONE), 32'd1);
      chk("valid_after_last", 32'(OUT_VALID), 32'd0);
      chk("idle_after_last", 32'(BUSY), 32'd0);
      dones += DONE;
      @(posedge CLK); #1;
      chk("done_cleared", 32'(DONE), 32'd0);
      dones += DONE;
      chk("done_count", 32'(dones), 32'd1);
      chk("no_restart", 32'(BUSY), 32'd0);
   endtask

   initial begin
      int n;
      for (int j = 0; j < NPE; j++) px[j] = 0;

      //        k  xs  xc    y  stall len lat  e0          step  rep
      vecs[0] = '{4,  1,  0,   2,  -1, 0, 16,  8,          8,    1'b0};
      vecs[1] = '{4,  1,  0,   2,   2, 5, 16,  8,          8,    1'b0};
      vecs[2] = '{0,  1,  0,   2,  -1, 0, 12,  0,          0,    1'b0};
      vecs[3] = '{4,  1,  0,   2,  -1, 0, 16,  8,          8,    1'b1};
`ifdef DRAIN_SAT_EN
      vecs[4] = '{1,  0,  300, 300, -1, 0, 13, 32767,      0,    1'b0};
      vecs[5] = '{1,  0, -300, 300, -1, 0, 13, -32768,     0,    1'b0};
`else
      vecs[4] = '{1,  0,  300, 300, -1, 0, 13, 90000,      0,    1'b0};
      vecs[5] = '{1,  0, -300, 300, -1, 0, 13, -90000,     0,    1'b0};
`endif
      vecs[6] = '{7, -2,  1,   3,   5, 2, 19, -21,        -42,   1'b0};

      #12;
      chk("rst_pe_rst_n", 32'(PE_RST_N), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_data", OUT_DATA, 32'd0);
      chk("rst_idx", 32'(OUT_IDX), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("pe_rst_n_after_rst", 32'(PE_RST_N), 32'd1);

      // Reset in the middle of a drain, at idx 3
      for (int j = 0; j < NPE; j++) px[j] = j + 1;
      tile_k = 2; tile_y = 1;
      K_LEN = 16'd2;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      OUT_READY = 1'b1;
      n = 0;
      while (!(OUT_VALID && OUT_IDX == 3'd3) && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("mid_drain_reached", 32'(n < 200), 32'd1);
      OUT_READY = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_valid", 32'(OUT_VALID), 32'd0);
      chk("abort_pe_rst_n", 32'(PE_RST_N), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      @(posedge CLK); #1;
      chk("abort_hold_pe_rst_n", 32'(PE_RST_N), 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("release_pe_rst_n", 32'(PE_RST_N), 32'd1);
      chk("release_valid", 32'(OUT_VALID), 32'd0);

      for (int i = 0; i < 7; i++) run_tile(vecs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
